// File: rtl/alu_pkg.sv
// Definitions shared by the addsub datapath, its operand logic and its result stage.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } alu_flags_t;

    // Occupancy of the two-entry result buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/flag_gen.sv
// Combinational zero / negative / signed-overflow derivation for an adder/subtractor result.
module flag_gen
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] s,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic         m,
    output logic         z,
    output logic         n,
    output logic         v
);

    logic b_eff_msb;

    always_comb begin
        // The adder sees B inverted when subtracting, so overflow uses the effective operand sign.
        b_eff_msb = b_msb ^ m;
        z         = (s == '0);
        n         = s[W-1];
        v         = (a_msb ^ s[W-1]) & (b_eff_msb ^ s[W-1]);
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result stage for addsub: flag capture, two-entry valid/ready buffer and
// a saturating signed-overflow event counter.
module addsub_result_stage
    import alu_pkg::*;
#(
    parameter int W  = ALU_W,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_s,
    input  logic          in_c,
    input  logic          in_a_msb,
    input  logic          in_b_msb,
    input  logic          in_m,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_s,
    output logic          out_c,
    output logic          out_z,
    output logic          out_n,
    output logic          out_v,
    output logic [CW-1:0] ovf_cnt,
    input  logic          clr_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    fifo_state_t  state_q;
    fifo_state_t  state_d;

    logic         push;
    logic         pop;
    logic         wr_head;

    logic         gen_z;
    logic         gen_n;
    logic         gen_v;
    alu_flags_t   in_flags;

    logic [W-1:0] head_s;
    logic [W-1:0] tail_s;
    alu_flags_t   head_f;
    alu_flags_t   tail_f;

    flag_gen #(
        .W (W)
    ) u_flag_gen (
        .s     (in_s),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .m     (in_m),
        .z     (gen_z),
        .n     (gen_n),
        .v     (gen_v)
    );

    always_comb begin
        in_flags.z = gen_z;
        in_flags.n = gen_n;
        in_flags.v = gen_v;
        in_flags.c = in_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FIFO_EMPTY: if (push) state_d = FIFO_ONE;
            FIFO_ONE: begin
                if (push && !pop) begin
                    state_d = FIFO_FULL;
                end else if (pop && !push) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_FULL:  if (pop) state_d = FIFO_ONE;
            default:    state_d = FIFO_EMPTY;
        endcase
    end

    // Handshake outputs depend on the registered state only, never on out_ready.
    always_comb begin
        in_ready  = (state_q != FIFO_FULL);
        out_valid = (state_q != FIFO_EMPTY);
    end

    always_comb begin
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        wr_head = push && ((state_q == FIFO_EMPTY) || ((state_q == FIFO_ONE) && pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_s <= '0;
            head_f <= '0;
            tail_s <= '0;
            tail_f <= '0;
        end else begin
            if (wr_head) begin
                head_s <= in_s;
                head_f <= in_flags;
            end else if (pop && (state_q == FIFO_FULL)) begin
                head_s <= tail_s;
                head_f <= tail_f;
            end
            if (push && !wr_head) begin
                tail_s <= in_s;
                tail_f <= in_flags;
            end
        end
    end

    always_comb begin
        out_s = head_s;
        out_c = head_f.c;
        out_z = head_f.z;
        out_n = head_f.n;
        out_v = head_f.v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (push && in_flags.v && (ovf_cnt != CNT_MAX)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: queue-based reference model compared every cycle,
// plus directed literal checks for the documented scenarios.
module tb_addsub_result_stage;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s;
    logic          in_c;
    logic          in_a_msb;
    logic          in_b_msb;
    logic          in_m;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_s;
    logic          out_c;
    logic          out_z;
    logic          out_n;
    logic          out_v;
    logic [CW-1:0] ovf_cnt;
    logic          clr_cnt;

    addsub_result_stage #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c      (in_c),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .in_m      (in_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_v     (out_v),
        .ovf_cnt   (ovf_cnt),
        .clr_cnt   (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int c;
        int z;
        int n;
        int v;
    } item_t;

    int    errors = 0;
    int    checks = 0;
    int    cur_a  = 0;
    int    cur_b  = 0;
    int    cur_m  = 0;
    item_t cur_item;
    item_t mq[$];
    int    m_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result of the operation computed arithmetically, independent of the adder structure.
    function automatic item_t golden(input int a, input int b, input int m);
        item_t it;
        int    sa;
        int    sb;
        int    r;
        sa   = (a > 7) ? a - 16 : a;
        sb   = (b > 7) ? b - 16 : b;
        r    = (m != 0) ? sa - sb : sa + sb;
        it.s = (m != 0) ? ((a - b + 16) % 16) : ((a + b) % 16);
        it.c = (m != 0) ? int'(a >= b) : int'(a + b > 15);
        it.z = int'(it.s == 0);
        it.n = int'(it.s >= 8);
        it.v = int'(r > 7 || r < -8);
        return it;
    endfunction

    task automatic drive(input int a, input int b, input int m, input logic v);
        item_t    it;
        logic [3:0] av;
        logic [3:0] bv;
        it       = golden(a, b, m);
        av       = 4'(a);
        bv       = 4'(b);
        cur_a    = a;
        cur_b    = b;
        cur_m    = m;
        cur_item = it;
        in_s     = 4'(it.s);
        in_c     = it.c[0];
        in_a_msb = av[3];
        in_b_msb = bv[3];
        in_m     = m[0];
        in_valid = v;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            bit p_push;
            bit p_pop;
            p_push = in_valid && (mq.size() < 2);
            p_pop  = (mq.size() > 0) && out_ready;
            if (clr_cnt) m_cnt = 0;
            else if (p_push && cur_item.v != 0 && m_cnt < 255) m_cnt++;
            if (p_pop) void'(mq.pop_front());
            if (p_push) mq.push_back(cur_item);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_in_ready", int'(in_ready), int'(mq.size() != 2));
            chk("model_out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("model_ovf_cnt", int'(ovf_cnt), m_cnt);
            if (mq.size() > 0) begin
                chk("model_out_s", int'(out_s), mq[0].s);
                chk("model_out_c", int'(out_c), mq[0].c);
                chk("model_out_z", int'(out_z), mq[0].z);
                chk("model_out_n", int'(out_n), mq[0].n);
                chk("model_out_v", int'(out_v), mq[0].v);
            end
        end
    end

    initial begin
        bit held;
        bit last_rdy;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        drive(0, 0, 0, 1'b0);
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_s", int'(out_s), 0);
        chk("rst_flags", int'({out_c, out_z, out_n, out_v}), 0);
        chk("rst_ovf_cnt", int'(ovf_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 + 4
        @(negedge clk);
        out_ready = 1'b1;
        drive(3, 4, 0, 1'b1);
        @(negedge clk);
        chk("add34_valid", int'(out_valid), 1);
        chk("add34_s", int'(out_s), 7);
        chk("add34_czvn", int'({out_c, out_z, out_n, out_v}), 0);
        drive(5, 5, 1, 1'b1);
        @(negedge clk);
        chk("sub55_s", int'(out_s), 0);
        chk("sub55_z", int'(out_z), 1);
        chk("sub55_c", int'(out_c), 1);
        chk("sub55_nv", int'({out_n, out_v}), 0);
        drive(7, 1, 0, 1'b1);
        @(negedge clk);
        chk("add71_s", int'(out_s), 8);
        chk("add71_n", int'(out_n), 1);
        chk("add71_v", int'(out_v), 1);
        chk("add71_ovf", int'(ovf_cnt), 1);
        in_valid = 1'b0;
        @(negedge clk);

        // backpressure with results 1, 2, 3
        out_ready = 1'b0;
        drive(1, 0, 0, 1'b1);
        @(negedge clk);
        drive(2, 0, 0, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_full", int'(in_ready), 0);
        drive(3, 0, 0, 1'b1);
        @(negedge clk);
        chk("bp_hold_ready", int'(in_ready), 0);
        chk("bp_head1", int'(out_s), 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head2", int'(out_s), 2);
        @(negedge clk);
        chk("bp_head3", int'(out_s), 3);
        in_valid = 1'b0;
        @(negedge clk);

        // saturation of the overflow counter
        drive(7, 1, 0, 1'b1);
        repeat (300) @(negedge clk);
        chk("ovf_saturated", int'(ovf_cnt), 255);
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("ovf_clear_priority", int'(ovf_cnt), 0);
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        // randomized traffic; a refused input is held until accepted
        held     = 1'b0;
        last_rdy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            held = in_valid && !last_rdy;
            if (!held) drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr_cnt   = 1'($urandom_range(0, 63) == 0);
            last_rdy  = in_ready;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        @(negedge clk);

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(7, 1, 0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("arst_pre_full", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_ovf_cnt", int'(ovf_cnt), 0);
        chk("arst_out_s", int'(out_s), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
# addsub_result_stage

Registered output stage directly downstream of the 4-bit `addsub` adder/subtractor. It captures each result (`S`, `C`), derives ALU status flags (zero, negative, signed overflow), and buffers up to two results behind a valid/ready handshake so a stalled consumer never loses an adder result. It also keeps a saturating count of signed-overflow events for debug and status readout.

## Interface
Parameters:
- `W`, 4: datapath width; must equal the `addsub` width.
- `CW`, 8: overflow event counter width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream result present this cycle.
- `in_ready`  out  1: stage can accept a result.
- `in_s`  in  W: adder sum `S`.
- `in_c`  in  1: adder carry-out `C`.
- `in_a_msb`  in  1: `A[W-1]` of the operation.
- `in_b_msb`  in  1: `B[W-1]` of the operation, before the `M` inversion.
- `in_m`  in  1: mode; 0 = add, 1 = subtract.
- `out_valid`  out  1: buffered result available.
- `out_ready`  in  1: consumer takes the result.
- `out_s`  out  W: result.
- `out_c`  out  1: raw carry. In subtract mode, 1 means no borrow.
- `out_z`, `out_n`, `out_v`  out  1 each: zero, negative, and signed-overflow flags.
- `ovf_cnt`  out  CW: saturating count of accepted results with V = 1.
- `clr_cnt`  in  1: synchronous clear of `ovf_cnt`.

## Operation
- Push: `in_valid && in_ready` at the clock edge.
- Pop: `out_valid && out_ready` at the clock edge.
- Flags are computed combinationally on input and stored with the entry:
  - Z = (`in_s` == 0)
  - N = `in_s[W-1]`
  - V = (`in_a_msb` ^ `in_s[W-1]`) & ((`in_b_msb` ^ `in_m`) ^ `in_s[W-1]`)
- Storage is a 2-entry FIFO: head register, tail register, and a 2-bit `count` taking values 0, 1 or 2.
  - Output fields always reflect the head entry.
  - A push with `count` == 0, or a push with a simultaneous pop at `count` == 1, writes the head.
  - Otherwise a push writes the tail. A pop moves tail to head.
- `count` transitions:
  - 0: push → 1.
  - 1: push-only → 2; pop-only → 0; push + pop → 1 (the new entry becomes head).
  - 2: pop → 1. No push is possible, because `in_ready` is 0.
- `in_ready` = (`count` != 2). It is decoded from registered `count` only, with no combinational path from `out_ready`.
- `out_valid` = (`count` != 0).
- `ovf_cnt`:
  - +1 on a push with V = 1.
  - Saturates at 2^CW − 1.
  - `clr_cnt` has priority. Clear and increment in the same cycle give 0.
- A push while `in_ready` = 0 is ignored. Upstream must hold its data.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally) sets:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1
  - `out_s` = 0, `out_c` = 0, `out_z` = 0, `out_n` = 0, `out_v` = 0
  - `ovf_cnt` = 0
- Reset mid-operation discards all buffered entries immediately. The outputs above take their reset values without waiting for a clock.
- Latency: a result pushed at edge k is visible on the outputs with `out_valid` = 1 after edge k, when the FIFO was empty.
- Throughput: one result per cycle while `out_ready` = 1.
- Data on `out_*` is stable while `out_valid` = 1 and `out_ready` = 0.
- Ordering is strict FIFO.

## Structure
- Shared package `alu_pkg` holds:
  - The `alu_flags_t` struct {z, n, v, c}.
  - The `ALU_W` = 4 constant.
  - The `ALU_ADD` = 0 / `ALU_SUB` = 1 mode constants, shared with `addsub` and its upstream operand logic.
- One natural sub-module: `flag_gen`, the combinational Z/N/V derivation. It is reused by any future wider ALU.

## Test plan
- Add 3 + 4, so `in_s` = 7, C = 0, M = 0, msbs 0/0 → one cycle later `out_s` = 7, `out_z` = `out_n` = `out_v` = 0, `out_c` = 0.
- Subtract 5 − 5, so `in_s` = 0, C = 1, M = 1, msbs 0/0 → `out_z` = 1, `out_c` = 1, `out_v` = 0, `out_n` = 0.
- Add 7 + 1, so `in_s` = 8, msbs 0/0, M = 0 → `out_n` = 1, `out_v` = 1, `ovf_cnt` = 1.
- Backpressure: hold `out_ready` = 0 and present results 1, 2, 3 → `in_ready` drops after the second push and result 3 is held. Then assert `out_ready` → outputs 1, 2, 3 appear in order, one per cycle.
- 300 overflowing pushes (CW = 8) → `ovf_cnt` = 255. Then `clr_cnt` together with an overflowing push → `ovf_cnt` = 0.
- With 2 entries buffered, pulse `rst_n` low between edges → `out_valid` = 0, `in_ready` = 1 and `ovf_cnt` = 0 before the next edge.
